bcd_countdown_7seg: RTL and testbench



---
 rtl/bcd_countdown_pkg.sv | 27 ++
 rtl/bcd_to_7seg.sv | 34 +++
 rtl/bcd_countdown_7seg.sv | 150 +++++++++++++++
 tb/tb_bcd_countdown_7seg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_pkg
// Description : Shared types and constants for the two-digit BCD countdown
//               timer and its seven-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] DIG_UNITS = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;

  // Saturate a raw nibble to the largest legal BCD digit
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational 4-bit BCD to active-low seven-segment decoder
//               (bit0 = a ... bit6 = g). Non-BCD codes blank the digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import bcd_countdown_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Segment lookup, gfedcba ordering, low = lit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_7seg
// Description : Two-digit BCD down-counter with tick prescaler, terminal-count
//               flags and a multiplexed active-low seven-segment driver.
//               Optional macro COUNTDOWN_WRAP_EN turns it into a periodic
//               timer that reloads the last load value after reaching 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_7seg
  import bcd_countdown_pkg::*;
#(
  parameter int TICK_DIV = 12000000,
  parameter int SCAN_DIV = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       zero,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] C_SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_scan;
  logic          r_digit;        // 0 = units shown, 1 = tens shown
  logic [7:0]    r_count;
  logic [7:0]    w_count_next;
  logic          r_zero;
  logic          r_done;
  logic          w_done_next;
  logic          w_tick;
  logic [7:0]    w_load_clamped;
  logic [7:0]    w_count_dec;
  logic [3:0]    w_digit_bcd;

`ifdef COUNTDOWN_WRAP_EN
  logic [7:0]    r_last_load;
`endif

  assign w_load_clamped = {bcd_clamp(load_val[7:4]), bcd_clamp(load_val[3:0])};
  assign w_tick         = en && (r_state == RUN) && (r_presc == C_TICK_LAST);
  // BCD decrement: borrow from tens when units are already 0
  assign w_count_dec    = (r_count[3:0] == 4'd0) ?
                          {r_count[7:4] - 4'd1, BCD_MAX} :
                          {r_count[7:4], r_count[3:0] - 4'd1};

  // Next-state, next-count and done-pulse decision; load wins over a tick
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    if (load) begin
      w_count_next = w_load_clamped;
      w_state_next = (w_load_clamped != 8'h00) ? RUN : DONE;
    end else if (w_tick) begin
`ifdef COUNTDOWN_WRAP_EN
      if (r_count == 8'h00) begin
        w_count_next = r_last_load;
      end else begin
        w_count_next = w_count_dec;
        w_done_next  = (w_count_dec == 8'h00);
      end
`else
      w_count_next = w_count_dec;
      if (w_count_dec == 8'h00) begin
        w_state_next = DONE;
        w_done_next  = 1'b1;
      end
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Count value with registered zero compare and one-cycle done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'h00;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_zero  <= (w_count_next == 8'h00);
      r_done  <= w_done_next;
    end
  end

  // Tick prescaler: cleared by load, frozen while en is low or not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (load) begin
      r_presc <= '0;
    end else if (en && (r_state == RUN)) begin
      r_presc <= (r_presc == C_TICK_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  // Digit scan timer; flips the displayed digit each time it wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan  <= '0;
      r_digit <= 1'b0;
    end else if (r_scan == C_SCAN_LAST) begin
      r_scan  <= '0;
      r_digit <= ~r_digit;
    end else begin
      r_scan  <= r_scan + 1'b1;
    end
  end

`ifdef COUNTDOWN_WRAP_EN
  // Remembers the clamped preset so the timer can restart itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_last_load <= 8'h00;
    else if (load) r_last_load <= w_load_clamped;
  end
`endif

  // Digit mux feeds a single decoder so seg and dig_sel change together
  assign w_digit_bcd = r_digit ? r_count[7:4] : r_count[3:0];
  assign dig_sel     = r_digit ? DIG_TENS : DIG_UNITS;

  bcd_to_7seg u_dec (
    .bcd (w_digit_bcd),
    .seg (seg)
  );

  assign count = r_count;
  assign zero  = r_zero;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_countdown_7seg
// Description : Directed self-checking bench for bcd_countdown_7seg with
//               TICK_DIV=4 and SCAN_DIV=2, using an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_7seg;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic [7:0] count;
  logic       zero;
  logic       done;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];

  bcd_countdown_7seg #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .zero     (zero),
    .done     (done),
    .seg      (seg),
    .dig_sel  (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    push("rst_count", 16'h00); push("rst_zero", 16'h1); push("rst_done", 16'h0);
    push("rst_dig", 16'h2); push("rst_seg", 16'b1000000);
    #1;
    chk(count); chk(zero); chk(done); chk(dig_sel); chk(seg);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1);

    // Count down 12 -> 11 -> 10 -> 09
    en = 1'b1;
    do_load(8'h12);
    push("a_load", 16'h12); push("a_zero", 16'h0);
    chk(count); chk(zero);
    cyc(3); push("a_pre_tick", 16'h12); chk(count);
    cyc(1); push("a_11", 16'h11); chk(count);
    cyc(4); push("a_10", 16'h10); chk(count);
    cyc(4); push("a_09", 16'h09); chk(count);
    for (int i = 0; i < 4 && dig_sel != 2'b10; i++) cyc(1);
    push("a_units_dig", 16'h2); push("a_units_seg", 16'b0010000);
    chk(dig_sel); chk(seg);
    for (int i = 0; i < 4 && dig_sel != 2'b01; i++) cyc(1);
    push("a_tens_dig", 16'h1); push("a_tens_seg", 16'b1000000);
    chk(dig_sel); chk(seg);

    // Terminal count from 01 with one-cycle done pulse, then hold
    do_load(8'h01);
    cyc(3); push("b_pre", 16'h01); push("b_pre_done", 16'h0);
    chk(count); chk(done);
    cyc(1); push("b_zero_cnt", 16'h00); push("b_done", 16'h1); push("b_zero", 16'h1);
    chk(count); chk(done); chk(zero);
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      push("b_hold_done", 16'h0); push("b_hold_cnt", 16'h00);
      chk(done); chk(count);
    end

    // Clamp of illegal digits, then load of 00 without a done pulse
    do_load(8'h3F);
    push("c_clamp", 16'h39); push("c_clamp_zero", 16'h0);
    chk(count); chk(zero);
    do_load(8'h00);
    push("c_load0", 16'h00); push("c_load0_zero", 16'h1); push("c_load0_done", 16'h0);
    chk(count); chk(zero); chk(done);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      push("c_idle_done", 16'h0); push("c_idle_cnt", 16'h00);
      chk(done); chk(count);
    end

    // Load collides with a tick: load wins and restarts the prescaler
    do_load(8'h30);
    cyc(3);
    do_load(8'h25);
    push("d_load_wins", 16'h25); chk(count);
    cyc(3); push("d_no_early", 16'h25); chk(count);
    cyc(1); push("d_dec", 16'h24); chk(count);

    // Enable gap freezes the prescaler, then async reset mid-run
    do_load(8'h20);
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      push("e_gap", 16'h20); chk(count);
    end
    en = 1'b1;
    cyc(1); push("e_resume", 16'h20); chk(count);
    cyc(1); push("e_borrow", 16'h19); chk(count);
    #3 rst = 1'b1;
    push("e_rst_cnt", 16'h00); push("e_rst_dig", 16'h2); push("e_rst_zero", 16'h1);
    push("e_rst_done", 16'h0); push("e_rst_seg", 16'b1000000);
    #1;
    chk(count); chk(dig_sel); chk(zero); chk(done); chk(seg);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
